// File: rtl/narrow_pack.sv
// Narrows 32-bit words to 16 bits through a 2-entry in-order output buffer and
// counts overflowing pushes. Define NARROW_SAT_EN to saturate non-fitting words.
module narrow_pack #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_sext,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic             out_ovf,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] ovf_cnt,
    output logic [1:0]       dbg_state_o
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both 1; ready never depends on valid on the same side.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [15:0]      head_data_q, head_data_d;
    logic             head_ovf_q, head_ovf_d;
    logic [15:0]      tail_data_q, tail_data_d;
    logic             tail_ovf_q, tail_ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             push, pop, fits;
    logic [15:0]      narrow_data;

    assign in_ready    = (state_q != FULL);
    assign out_valid   = (state_q != EMPTY);
    assign out_data    = head_data_q;
    assign out_ovf     = head_ovf_q;
    assign ovf_cnt     = cnt_q;
    assign dbg_state_o = state_q;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_comb begin
        fits        = in_sext ? ((&in_data[31:15]) || !(|in_data[31:15]))
                              : !(|in_data[31:16]);
        narrow_data = in_data[15:0];
`ifdef NARROW_SAT_EN
        if (!fits) begin
            if (in_sext) narrow_data = in_data[31] ? 16'h8000 : 16'h7FFF;
            else         narrow_data = 16'hFFFF;
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        head_data_d = head_data_q;
        head_ovf_d  = head_ovf_q;
        tail_data_d = tail_data_q;
        tail_ovf_d  = tail_ovf_q;
        case (state_q)
            EMPTY: begin
                if (push) begin
                    head_data_d = narrow_data;
                    head_ovf_d  = !fits;
                    state_d     = ONE;
                end
            end
            ONE: begin
                if (push && pop) begin
                    head_data_d = narrow_data;
                    head_ovf_d  = !fits;
                end else if (push) begin
                    tail_data_d = narrow_data;
                    tail_ovf_d  = !fits;
                    state_d     = FULL;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // Second entry moves to the head; no push is possible here.
                if (pop) begin
                    head_data_d = tail_data_q;
                    head_ovf_d  = tail_ovf_q;
                    state_d     = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr_cnt)
            cnt_d = '0;
        else if (push && !fits && !(&cnt_q))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            head_data_q <= 16'h0000;
            head_ovf_q  <= 1'b0;
            tail_data_q <= 16'h0000;
            tail_ovf_q  <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            head_data_q <= head_data_d;
            head_ovf_q  <= head_ovf_d;
            tail_data_q <= tail_data_d;
            tail_ovf_q  <= tail_ovf_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_narrow_pack.sv
// Directed bench for narrow_pack: reset, fit/overflow narrowing, back-pressure,
// counter saturation/clear and reset while full.
module tb_narrow_pack;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_sext;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_ovf;
    logic        clr_cnt;
    logic [7:0]  ovf_cnt;
    logic [1:0]  dbg_state;

    int n_cmp = 0;
    int n_err = 0;

`ifdef NARROW_SAT_EN
    localparam logic [15:0] EXP_U8000 = 16'hFFFF;
    localparam logic [15:0] EXP_S10000 = 16'h7FFF;
`else
    localparam logic [15:0] EXP_U8000 = 16'h8000;
    localparam logic [15:0] EXP_S10000 = 16'h0000;
`endif

    narrow_pack #(.CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sext    (in_sext),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_ovf    (out_ovf),
        .clr_cnt    (clr_cnt),
        .ovf_cnt    (ovf_cnt),
        .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; inputs change and outputs are sampled 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d, input logic s);
        in_valid = 1'b1;
        in_data  = d;
        in_sext  = s;
        step();
        in_valid = 1'b0;
        in_data  = 32'hDEAD_BEEF;
        in_sext  = ~s;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_sext = 1'b0;
        out_ready = 1'b1; clr_cnt = 1'b0;
        step(); step();
        rst_n = 1'b1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'h0);
        check("rst_out_ovf",   32'(out_ovf),   32'd0);
        check("rst_ovf_cnt",   32'(ovf_cnt),   32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_state",     32'(dbg_state), 32'd0);

        push(32'h0000_7FFF, 1'b1);
        check("s7fff_valid", 32'(out_valid), 32'd1);
        check("s7fff_data",  32'(out_data),  32'h7FFF);
        check("s7fff_ovf",   32'(out_ovf),   32'd0);
        check("s7fff_cnt",   32'(ovf_cnt),   32'd0);
        step();
        check("drain_empty", 32'(out_valid), 32'd0);

        push(32'hFFFF_8000, 1'b1);
        check("s8000_data", 32'(out_data), 32'h8000);
        check("s8000_ovf",  32'(out_ovf),  32'd0);
        push(32'hFFFF_8000, 1'b0);
        check("u8000_data", 32'(out_data), 32'(EXP_U8000));
        check("u8000_ovf",  32'(out_ovf),  32'd1);
        check("u8000_cnt",  32'(ovf_cnt),  32'd1);
        push(32'h0001_0000, 1'b1);
        check("s10000_data", 32'(out_data), 32'(EXP_S10000));
        check("s10000_ovf",  32'(out_ovf),  32'd1);
        check("s10000_cnt",  32'(ovf_cnt),  32'd2);
        step();
        check("drain2_empty", 32'(out_valid), 32'd0);

        // Back-pressure: two pushes fill the buffer, the third is refused.
        out_ready = 1'b0;
        push(32'h0000_1234, 1'b0);
        check("bp1_ready", 32'(in_ready), 32'd1);
        push(32'hFFFF_FFFE, 1'b1);
        check("bp2_ready", 32'(in_ready), 32'd0);
        check("bp2_state", 32'(dbg_state), 32'd2);
        push(32'h0000_5555, 1'b0);
        check("bp3_head", 32'(out_data), 32'h1234);
        check("bp3_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        step();
        check("bp_pop1_data",  32'(out_data),  32'hFFFE);
        check("bp_pop1_ovf",   32'(out_ovf),   32'd0);
        check("bp_pop1_valid", 32'(out_valid), 32'd1);
        check("bp_pop1_ready", 32'(in_ready),  32'd1);
        step();
        check("bp_pop2_valid", 32'(out_valid), 32'd0);
        check("bp_cnt", 32'(ovf_cnt), 32'd2);

        // Counter saturation then clear with a simultaneous overflowing push.
        in_valid = 1'b1; in_data = 32'h0001_0000; in_sext = 1'b0;
        for (int i = 0; i < 300; i++) step();
        check("sat_cnt", 32'(ovf_cnt), 32'hFF);
        clr_cnt = 1'b1;
        step();
        check("clr_cnt", 32'(ovf_cnt), 32'd0);
        clr_cnt = 1'b0; in_valid = 1'b0;
        step();
        check("clr_hold", 32'(ovf_cnt), 32'd0);
        step();

        // Reset while full discards both entries and the counter.
        out_ready = 1'b0;
        push(32'h0002_0000, 1'b0);
        push(32'h0003_0000, 1'b0);
        check("pre_rst_state", 32'(dbg_state), 32'd2);
        check("pre_rst_cnt",   32'(ovf_cnt),   32'd2);
        rst_n = 1'b0; in_valid = 1'b1; in_data = 32'h0004_0000; out_ready = 1'b1;
        step();
        rst_n = 1'b1; in_valid = 1'b0;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_ready", 32'(in_ready),  32'd1);
        check("mid_rst_cnt",   32'(ovf_cnt),   32'd0);
        check("mid_rst_data",  32'(out_data),  32'h0);
        step();
        check("post_rst_valid", 32'(out_valid), 32'd0);
        push(32'h0000_00AA, 1'b0);
        check("post_rst_data", 32'(out_data), 32'h00AA);
        check("post_rst_ovf",  32'(out_ovf),  32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/narrow_pack.md
NARROW_PACK -- requirements
Module: narrow_pack

Interface
REQ-001 Parameter CNT_W, default 8, SHALL set the width of the overflow event counter.
REQ-002 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  SHALL be the synchronous, active-low reset, sampled on the clk rising edge.
REQ-004 in_valid  input  1  SHALL mark in_data/in_sext as valid this cycle.
REQ-005 in_ready  output  1  SHALL mark that the block accepts a word this cycle.
REQ-006 in_data  input  32  SHALL be the wide word to be narrowed.
REQ-007 in_sext  input  1  SHALL select the interpretation: 1 = signed (two's complement), 0 = unsigned.
REQ-008 out_valid  output  1  SHALL mark out_data/out_ovf as valid.
REQ-009 out_ready  input  1  SHALL mark that the consumer takes the head entry this cycle.
REQ-010 out_data  output  16  SHALL be the narrowed result at the buffer head.
REQ-011 out_ovf  output  1  SHALL flag that the head entry's source did not fit in 16 bits.
REQ-012 clr_cnt  input  1  SHALL clear the overflow counter.
REQ-013 ovf_cnt  output  CNT_W  SHALL count accepted words that overflowed.

Function
REQ-014 A push SHALL occur when in_valid and in_ready are both 1; a pop SHALL occur when out_valid and out_ready are both 1.
REQ-015 The block SHALL hold a 2-entry, in-order output buffer controlled by FSM states EMPTY, ONE, FULL.
REQ-016 Transitions: EMPTY+push->ONE; ONE+push only->FULL; ONE+pop only->EMPTY; ONE+push+pop->ONE; FULL+pop->ONE; all other cases hold state.
REQ-017 in_ready SHALL be 1 in EMPTY and ONE and 0 in FULL, including a FULL cycle that also pops; no push SHALL occur in FULL.
REQ-018 out_valid SHALL be 1 in ONE and FULL; out_data and out_ovf SHALL present the oldest entry.
REQ-019 Latency: a word pushed at edge N SHALL be visible on out_data at edge N+1 when the buffer was empty.
REQ-020 Fit rule, signed: the word fits iff in_data[31:15] are all equal; unsigned: it fits iff in_data[31:16] == 0.
REQ-021 A word that fits SHALL produce out_data = in_data[15:0] and out_ovf = 0.
REQ-022 A non-fitting word SHALL produce out_ovf = 1; its out_data value is set by REQ-028/REQ-029.
REQ-023 ovf_cnt SHALL increment by 1 on each push with a non-fitting word, saturate at all-ones, and never wrap.
REQ-024 clr_cnt SHALL take priority over a same-cycle increment; the next value SHALL be 0.
REQ-025 Entries not yet popped SHALL be unaffected by in_data/in_sext changes after their push.

Reset
REQ-026 With rst_n = 0 at a clk edge, the block SHALL enter EMPTY and set out_valid = 0, out_data = 16'h0000, out_ovf = 0, ovf_cnt = 0, and in_ready = 1 from the following cycle.
REQ-027 Reset during operation SHALL discard all buffered entries; a push or pop in the reset cycle SHALL have no effect.

Configuration
REQ-028 With NARROW_SAT_EN defined, a non-fitting word SHALL saturate: signed positive -> 16'h7FFF, signed negative (in_data[31] = 1) -> 16'h8000, unsigned -> 16'hFFFF.
REQ-029 Without NARROW_SAT_EN, a non-fitting word SHALL truncate to in_data[15:0]; out_ovf and ovf_cnt behaviour SHALL be unchanged.

Verification
REQ-030 Reset, then push 32'h0000_7FFF with sext = 1, out_ready = 1 -> next cycle out_data = 16'h7FFF, out_ovf = 0, ovf_cnt = 0.
REQ-031 Push 32'hFFFF_8000 with sext = 1 -> out_data = 16'h8000, out_ovf = 0. Push the same word with sext = 0 -> out_ovf = 1, out_data = 16'hFFFF (SAT) or 16'h8000 (no SAT).
REQ-032 Push 32'h0001_0000 with sext = 1 -> out_ovf = 1, out_data = 16'h7FFF (SAT) or 16'h0000 (no SAT), and ovf_cnt increments by 1.
REQ-033 Hold out_ready = 0 and push three words -> in_ready = 0 after the second push, the third is not accepted, and after release the outputs appear in order with no loss or duplication.
REQ-034 Push 300 overflowing words with CNT_W = 8 -> ovf_cnt = 8'hFF; assert clr_cnt together with an overflowing push -> ovf_cnt = 0.
REQ-035 Fill the buffer to FULL, assert rst_n = 0 for one edge -> out_valid = 0, in_ready = 1, ovf_cnt = 0, and no stale entry appears afterwards.
